// File: rtl/fe25519_mul_param.sv
// rtl/fe25519_mul_param.sv - digit-serial GF(2^255-19) multiplier/squarer, canonical output, tag passthrough (optional FE25519_MUL_START_ERR_EN)
module fe25519_mul_param #(
    parameter int DIGIT_W = 4,
    parameter int TAG_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               op_sq,
    input  logic [254:0]       a,
    input  logic [254:0]       b,
    input  logic [TAG_W-1:0]   tag_in,
    output logic [254:0]       res,
    output logic [TAG_W-1:0]   tag_out,
    output logic               done,
`ifdef FE25519_MUL_START_ERR_EN
    output logic               err,
`endif
    output logic               busy
);

    localparam int ITER  = (255 + DIGIT_W - 1) / DIGIT_W;
    localparam int CNT_W = 9;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    // p = 2^255 - 19 written as all-ones minus 18
    localparam logic [254:0] P = ~255'd18;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MUL   = 3'd1;
    localparam logic [2:0] S_FOLD1 = 3'd2;
    localparam logic [2:0] S_FOLD2 = 3'd3;
    localparam logic [2:0] S_FINAL = 3'd4;

    logic [2:0]       state;
    logic [509:0]     a_reg;
    logic [254:0]     b_reg;
    logic [509:0]     prod;
    logic [CNT_W-1:0] cnt;
    logic [TAG_W-1:0] tag_reg;
    logic [260:0]     t1;
    logic [255:0]     t2;

    logic [509:0]     digit_ext;
    logic [509:0]     partial;
    logic [509:0]     prod_next;
    logic [260:0]     lo1_ext;
    logic [260:0]     hi1_ext;
    logic [260:0]     t1_next;
    logic [255:0]     lo2_ext;
    logic [255:0]     hi2_ext;
    logic [255:0]     t2_next;
    logic [255:0]     p_ext;
    logic [255:0]     t2_sub;
    logic [254:0]     res_next;

    assign busy = (state != S_IDLE);

    // Datapath for one MUL step and the two 2^255 == 19 folds plus the final conditional subtract
    always_comb begin
        digit_ext = 510'(b_reg[DIGIT_W-1:0]);
        partial   = a_reg * digit_ext;
        prod_next = prod + partial;

        // 19*H built as H<<4 + H<<1 + H; t1 < 20*2^255 fits in 261 bits
        lo1_ext   = {6'd0, prod[254:0]};
        hi1_ext   = {6'd0, prod[509:255]};
        t1_next   = lo1_ext + (hi1_ext << 4) + (hi1_ext << 1) + hi1_ext;

        // upper part of t1 is at most 63, so t2 < 2^255 + 1197 < 2p
        lo2_ext   = {1'b0, t1[254:0]};
        hi2_ext   = {250'd0, t1[260:255]};
        t2_next   = lo2_ext + (hi2_ext << 4) + (hi2_ext << 1) + hi2_ext;

        p_ext     = {1'b0, P};
        t2_sub    = t2 - p_ext;
        res_next  = (t2 >= p_ext) ? t2_sub[254:0] : t2[254:0];
    end

    // Control FSM and all datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            prod    <= '0;
            cnt     <= '0;
            tag_reg <= '0;
            t1      <= '0;
            t2      <= '0;
            res     <= '0;
            tag_out <= '0;
            done    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg   <= {255'd0, a};
                        b_reg   <= op_sq ? a : b;
                        tag_reg <= tag_in;
                        prod    <= '0;
                        cnt     <= '0;
                        state   <= S_MUL;
                    end
                end
                S_MUL: begin
                    prod  <= prod_next;
                    a_reg <= a_reg << DIGIT_W;
                    b_reg <= b_reg >> DIGIT_W;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= S_FOLD1;
                    end
                end
                S_FOLD1: begin
                    t1    <= t1_next;
                    state <= S_FOLD2;
                end
                S_FOLD2: begin
                    t2    <= t2_next;
                    state <= S_FINAL;
                end
                S_FINAL: begin
                    res     <= res_next;
                    tag_out <= tag_reg;
                    done    <= 1'b1;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FE25519_MUL_START_ERR_EN
    // Sticky flag for a request dropped because an operation was in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (start && busy) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fe25519_mul_param.sv
// tb/tb_fe25519_mul_param.sv - directed and random checks for fe25519_mul_param
module tb_fe25519_mul_param;

    localparam int TAG_W = 4;
    localparam logic [254:0] P = ~255'd18;

    logic               clk;
    logic               rst;
    logic               start;
    logic               start_alt;
    logic               op_sq;
    logic [254:0]       a;
    logic [254:0]       b;
    logic [TAG_W-1:0]   tag_in;

    logic [254:0]       res,  res1,  res2,  res8;
    logic [TAG_W-1:0]   tag_out, tag1, tag2, tag8;
    logic               done, done1, done2, done8;
    logic               busy, busy1, busy2, busy8;
`ifdef FE25519_MUL_START_ERR_EN
    logic               err, err1, err2, err8;
`endif

    int checks;
    int failures;

    fe25519_mul_param #(.DIGIT_W(4), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .start(start), .op_sq(op_sq), .a(a), .b(b), .tag_in(tag_in),
        .res(res), .tag_out(tag_out), .done(done),
`ifdef FE25519_MUL_START_ERR_EN
        .err(err),
`endif
        .busy(busy));

    fe25519_mul_param #(.DIGIT_W(1), .TAG_W(TAG_W)) dut1 (
        .clk(clk), .rst(rst), .start(start_alt), .op_sq(op_sq), .a(a), .b(b), .tag_in(tag_in),
        .res(res1), .tag_out(tag1), .done(done1),
`ifdef FE25519_MUL_START_ERR_EN
        .err(err1),
`endif
        .busy(busy1));

    fe25519_mul_param #(.DIGIT_W(2), .TAG_W(TAG_W)) dut2 (
        .clk(clk), .rst(rst), .start(start_alt), .op_sq(op_sq), .a(a), .b(b), .tag_in(tag_in),
        .res(res2), .tag_out(tag2), .done(done2),
`ifdef FE25519_MUL_START_ERR_EN
        .err(err2),
`endif
        .busy(busy2));

    fe25519_mul_param #(.DIGIT_W(8), .TAG_W(TAG_W)) dut8 (
        .clk(clk), .rst(rst), .start(start_alt), .op_sq(op_sq), .a(a), .b(b), .tag_in(tag_in),
        .res(res8), .tag_out(tag8), .done(done8),
`ifdef FE25519_MUL_START_ERR_EN
        .err(err8),
`endif
        .busy(busy8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [254:0] ref_mul(input logic [254:0] x, input logic [254:0] y);
        logic [509:0] prod;
        logic [509:0] r;
        prod = {255'd0, x} * {255'd0, y};
        r = prod % {255'd0, P};
        return r[254:0];
    endfunction

    function automatic logic [254:0] rand255();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v[254:0];
    endfunction

    task automatic check(input string tag, input logic [254:0] obs, input logic [254:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_op(input logic [254:0] x, input logic [254:0] y, input logic sq,
                          input logic [TAG_W-1:0] t, output int cyc);
        a = x; b = y; op_sq = sq; tag_in = t; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 255'(busy), 255'd1);
        wait_done(cyc);
    endtask

    logic [254:0] x_op, y_op, r_a, r_b;
    logic [TAG_W-1:0] r_t;
    logic         r_sq;
    int           cyc;
    int           c1, c2, c8, n;

    initial begin
        checks = 0; failures = 0;
        rst = 1'b0; start = 1'b0; start_alt = 1'b0; op_sq = 1'b0;
        a = '0; b = '0; tag_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_res", res, 255'd0);
        check("reset_tag", 255'(tag_out), 255'd0);
        check("reset_done", 255'(done), 255'd0);
        check("reset_busy", 255'(busy), 255'd0);
`ifdef FE25519_MUL_START_ERR_EN
        check("reset_err", 255'(err), 255'd0);
`endif
        rst = 1'b1;
        @(posedge clk); #1;

        // square 2^128 on all digit widths, b must be ignored
        a = 255'd1 << 128; b = {7'h5A, {31{8'h5A}}}; op_sq = 1'b1; tag_in = 4'd7;
        start_alt = 1'b1;
        @(posedge clk); #1;
        start_alt = 1'b0;
        c1 = -1; c2 = -1; c8 = -1;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            if (done1 === 1'b1 && c1 < 0) c1 = k;
            if (done2 === 1'b1 && c2 < 0) c2 = k;
            if (done8 === 1'b1 && c8 < 0) c8 = k;
        end
        check("sq_w1_latency", 255'(c1), 255'd258);
        check("sq_w2_latency", 255'(c2), 255'd131);
        check("sq_w8_latency", 255'(c8), 255'd35);
        check("sq_w1_res", res1, 255'd38);
        check("sq_w2_res", res2, 255'd38);
        check("sq_w8_res", res8, 255'd38);
        check("sq_w8_tag", 255'(tag8), 255'd7);

        run_op(255'd1 << 128, {7'h5A, {31{8'h5A}}}, 1'b1, 4'd2, cyc);
        check("sq_w4_latency", 255'(cyc), 255'd67);
        check("sq_w4_res", res, 255'd38);

        // canonical wrap (p-1)^2 = 1
        run_op(P - 255'd1, P - 255'd1, 1'b0, 4'd3, cyc);
        check("wrap_latency", 255'(cyc), 255'd67);
        check("wrap_res", res, 255'd1);
        check("wrap_tag", 255'(tag_out), 255'd3);
        check("wrap_done", 255'(done), 255'd1);
        @(posedge clk); #1;
        check("done_pulse_one_cycle", 255'(done), 255'd0);
        check("res_held", res, 255'd1);

        run_op(~255'd0, 255'd1, 1'b0, 4'd4, cyc);
        check("noncanon_a_res", res, 255'd18);
        run_op(255'd2, P - 255'd1, 1'b0, 4'd5, cyc);
        check("two_times_pm1_res", res, P - 255'd2);
        run_op(255'd0, rand255(), 1'b0, 4'd6, cyc);
        check("zero_res", res, 255'd0);

        // back-to-back with an ignored mid-operation request
        x_op = 255'h1234_5678_9abc_def0_0fed_cba9_8765_4321;
        y_op = (P - 255'd12345) ^ 255'hffff;
        a = x_op; b = y_op; op_sq = 1'b0; tag_in = 4'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        repeat (10) begin @(posedge clk); #1; cyc++; end
        a = 255'd99; b = 255'd77; tag_in = 4'd9; op_sq = 1'b1; start = 1'b1;
        @(posedge clk); #1; cyc++;
        start = 1'b0;
        while (done !== 1'b1 && cyc < 400) begin @(posedge clk); #1; cyc++; end
        check("b2b_first_latency", 255'(cyc), 255'd67);
        check("b2b_first_res", res, ref_mul(x_op, y_op));
        check("b2b_first_tag", 255'(tag_out), 255'd5);
`ifdef FE25519_MUL_START_ERR_EN
        check("err_sticky", 255'(err), 255'd1);
`endif
        // start in the done cycle
        run_op(y_op, y_op, 1'b1, 4'd6, cyc);
        check("b2b_second_latency", 255'(cyc), 255'd67);
        check("b2b_second_res", res, ref_mul(y_op, y_op));
        check("b2b_second_tag", 255'(tag_out), 255'd6);

        // reset in the middle of MUL
        a = 255'd11; b = 255'd13; op_sq = 1'b0; tag_in = 4'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("midreset_res", res, 255'd0);
        check("midreset_done", 255'(done), 255'd0);
        check("midreset_busy", 255'(busy), 255'd0);
        check("midreset_tag", 255'(tag_out), 255'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_op(255'd5, 255'd7, 1'b0, 4'd1, cyc);
        check("after_reset_res", res, 255'd35);
        check("after_reset_latency", 255'(cyc), 255'd67);

        // random regression against a modular-arithmetic model
        for (n = 0; n < 100; n++) begin
            r_a = rand255(); r_b = rand255();
            if (n % 10 == 0) r_a = P + 255'(n);
            r_sq = 1'($urandom_range(0, 1));
            r_t = TAG_W'($urandom);
            run_op(r_a, r_b, r_sq, r_t, cyc);
            check("rand_res", res, ref_mul(r_a, r_sq ? r_a : r_b));
            check("rand_tag", 255'(tag_out), 255'(r_t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
